// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package riscv_mem_pkg;

    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // An access is misaligned when the low address bits below its natural size are non-zero.
    function automatic logic is_misaligned(input logic [2:0] offset, input logic [1:0] size);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = (offset[0] != 1'b0);
            SZ_W:    mis = (offset[1:0] != 2'b00);
            default: mis = (offset != 3'b000);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: load extraction/extension, store byte enables and data shift.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [2:0]  offset,
    input  logic [63:0] rword,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [7:0]  byte_en,
    output logic [63:0] store_data
);

    logic [5:0]  bit_off_s;
    logic [63:0] shifted_s;

    assign bit_off_s = {offset, 3'b000};

    // Shift the addressed lanes down for loads and the store data up into place, then size-mask.
    always_comb begin
        shifted_s  = rword >> bit_off_s;
        store_data = wdata << bit_off_s;
        load_data  = 64'd0;
        byte_en    = 8'h00;
        case (size)
            SZ_B: begin
                load_data = is_unsigned ? {56'd0, shifted_s[7:0]}
                                        : {{56{shifted_s[7]}}, shifted_s[7:0]};
                byte_en   = 8'h01 << offset;
            end
            SZ_H: begin
                load_data = is_unsigned ? {48'd0, shifted_s[15:0]}
                                        : {{48{shifted_s[15]}}, shifted_s[15:0]};
                byte_en   = 8'h03 << offset;
            end
            SZ_W: begin
                load_data = is_unsigned ? {32'd0, shifted_s[31:0]}
                                        : {{32{shifted_s[31]}}, shifted_s[31:0]};
                byte_en   = 8'h0F << offset;
            end
            default: begin
                // Full doubleword: extension mode is irrelevant.
                load_data = shifted_s;
                byte_en   = 8'hFF << offset;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with a doubleword storage array.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit DIRECT = (LATENCY == 1);

    state_e             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               cap_wr_r;
    logic [1:0]         cap_size_r;
    logic               cap_uns_r;
    logic [63:0]        cap_addr_r;
    logic [63:0]        cap_wdata_r;
    logic [63:0]        mem_r [DEPTH];

    logic               accept_s;
    logic               sel_wr_s;
    logic [1:0]         sel_size_s;
    logic               sel_uns_s;
    logic [63:0]        sel_addr_s;
    logic [63:0]        sel_wdata_s;
    logic               err_s;
    logic [IDX_W-1:0]   idx_s;
    logic [63:0]        rword_s;
    logic [63:0]        load_data_s;
    logic [7:0]         byte_en_s;
    logic [63:0]        store_data_s;
    logic [63:0]        resp_data_s;
    logic               enter_resp_s;
    logic               commit_s;

    assign accept_s = req_valid & req_ready;

    // With LATENCY=1 the access resolves on the acceptance edge, so use live inputs while idle.
    always_comb begin
        sel_wr_s    = cap_wr_r;
        sel_size_s  = cap_size_r;
        sel_uns_s   = cap_uns_r;
        sel_addr_s  = cap_addr_r;
        sel_wdata_s = cap_wdata_r;
        if (state_r == IDLE) begin
            sel_wr_s    = req_wr;
            sel_size_s  = req_size;
            sel_uns_s   = req_unsigned;
            sel_addr_s  = req_addr;
            sel_wdata_s = req_wdata;
        end else begin
            sel_wr_s    = cap_wr_r;
        end
    end

    assign err_s = (sel_addr_s[63:3] >= 61'(DEPTH)) | is_misaligned(sel_addr_s[2:0], sel_size_s);
    assign idx_s = sel_addr_s[IDX_W+2:3];

    // Read the addressed doubleword; errored accesses never touch the array.
    always_comb begin
        rword_s = 64'd0;
        if (!err_s) begin
            rword_s = mem_r[idx_s];
        end else begin
            rword_s = 64'd0;
        end
    end

    mem_lane_align u_align (
        .size        (sel_size_s),
        .is_unsigned (sel_uns_s),
        .offset      (sel_addr_s[2:0]),
        .rword       (rword_s),
        .wdata       (sel_wdata_s),
        .load_data   (load_data_s),
        .byte_en     (byte_en_s),
        .store_data  (store_data_s)
    );

    assign resp_data_s  = (err_s | sel_wr_s) ? 64'd0 : load_data_s;
    assign enter_resp_s = (DIRECT && (state_r == IDLE) && accept_s) ||
                          ((state_r == WAIT) && (cnt_r == 4'd0));
    assign commit_s     = enter_resp_s & sel_wr_s & ~err_s;

    // Commit enabled store bytes on the edge entering RESP; storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (commit_s) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= store_data_s[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 64'd0;
            rsp_err     <= 1'b0;
            cap_wr_r    <= 1'b0;
            cap_size_r  <= 2'd0;
            cap_uns_r   <= 1'b0;
            cap_addr_r  <= 64'd0;
            cap_wdata_r <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cap_wr_r    <= req_wr;
                        cap_size_r  <= req_size;
                        cap_uns_r   <= req_unsigned;
                        cap_addr_r  <= req_addr;
                        cap_wdata_r <= req_wdata;
                        req_ready   <= 1'b0;
                        if (DIRECT) begin
                            state_r   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= resp_data_s;
                            rsp_err   <= err_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= 4'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= resp_data_s;
                        rsp_err   <= err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    // req_ready only rises after the handshake edge, never on it.
                    if (rsp_ready) begin
                        state_r   <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 64'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= 4'd0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 64'd0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
